// File: rtl/wave_sched.sv
// Time-multiplexed DDFS sequencer: N_CH phase accumulators share one registered-output
// sine ROM; each sample_tick sweeps all channels and captures one ROM word per channel.
//
// state | meaning
// IDLE  | waiting for sample_tick
// ISSUE | one channel per cycle: present address, step phase, push tag
// DRAIN | two cycles while the ROM and tag pipeline empty
module wave_sched #(
    parameter int N_CH        = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_tick,
    input  logic                         fcw_wr,
    input  logic [$clog2(N_CH)-1:0]      fcw_ch,
    input  logic [PHASE_WIDTH-1:0]       fcw_data,
    input  logic [N_CH-1:0]              ch_en,
    input  logic                         overrun_clr,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic [DATA_WIDTH-1:0]        rom_data,
    output logic [N_CH*DATA_WIDTH-1:0]   sample_o,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         overrun
);
    localparam int CW = $clog2(N_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state;
    logic [CW-1:0]          ch;
    logic                   drain_cnt;
    logic [PHASE_WIDTH-1:0] phase   [N_CH];
    logic [PHASE_WIDTH-1:0] fcw_sh  [N_CH];
    logic [PHASE_WIDTH-1:0] fcw_act [N_CH];
    logic [DATA_WIDTH-1:0]  sample  [N_CH];

    // Tag stage 1 aligns with rom_addr, stage 2 with rom_data.
    logic                   tag1_v, tag1_en, tag2_v, tag2_en;
    logic [CW-1:0]          tag1_id, tag2_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= '0;
            drain_cnt    <= 1'b0;
            rom_addr     <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            tag1_v       <= 1'b0;
            tag1_en      <= 1'b0;
            tag1_id      <= '0;
            tag2_v       <= 1'b0;
            tag2_en      <= 1'b0;
            tag2_id      <= '0;
            for (int k = 0; k < N_CH; k++) begin
                phase[k]   <= '0;
                fcw_sh[k]  <= '0;
                fcw_act[k] <= '0;
                sample[k]  <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            tag1_v       <= 1'b0;

            if (fcw_wr && (int'(fcw_ch) < N_CH))
                fcw_sh[fcw_ch] <= fcw_data;

            if (sample_tick && busy)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            tag2_v  <= tag1_v;
            tag2_en <= tag1_en;
            tag2_id <= tag1_id;

            if (tag2_v) begin
                sample[tag2_id] <= tag2_en ? rom_data : '0;
                if (tag2_id == LAST_CH)
                    sample_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        ch    <= '0;
                        for (int k = 0; k < N_CH; k++)
                            fcw_act[k] <= fcw_sh[k];
                    end
                end
                ISSUE: begin
                    rom_addr  <= phase[ch][PHASE_WIDTH-1 -: ADDR_WIDTH];
                    phase[ch] <= ch_en[ch] ? phase[ch] + fcw_act[ch] : '0;
                    tag1_v    <= 1'b1;
                    tag1_en   <= ch_en[ch];
                    tag1_id   <= ch;
                    if (ch == LAST_CH) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sample_o = '0;
        for (int k = 0; k < N_CH; k++)
            sample_o[k*DATA_WIDTH +: DATA_WIDTH] = sample[k];
    end

endmodule

// File: tb/tb_wave_sched.sv
// Bench for wave_sched: directed sweep table, reset-mid-sweep sequence and randomized
// sweeps checked against a per-channel phase/sample model.
module tb_wave_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick, fcw_wr, overrun_clr;
    logic [1:0]  fcw_ch;
    logic [31:0] fcw_data;
    logic [3:0]  ch_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [63:0] sample_o;
    logic        sample_valid, busy, overrun;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_ph [4];
    logic [31:0] m_sh [4];
    logic [31:0] m_act[4];
    logic [15:0] m_smp[4];
    logic        m_ov;

    typedef struct {
        logic [3:0]      en;
        int              wr_at;
        logic [1:0]      wr_ch;
        logic [31:0]     wr_data;
        int              ov_at;
        int              clr_at;
        logic [3:0][7:0] ea;
        logic            eov;
    } vec_t;

    vec_t vec[7];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= 16'h1000 + {8'h00, rom_addr};

    wave_sched #(.N_CH(4), .PHASE_WIDTH(32), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .fcw_wr(fcw_wr),
        .fcw_ch(fcw_ch), .fcw_data(fcw_data), .ch_en(ch_en), .overrun_clr(overrun_clr),
        .rom_addr(rom_addr), .rom_data(rom_data), .sample_o(sample_o),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ph[k] = '0; m_sh[k] = '0; m_act[k] = '0; m_smp[k] = '0;
        end
        m_ov = 1'b0;
    endtask

    task automatic wr_fcw(input logic [1:0] c, input logic [31:0] d);
        fcw_wr = 1'b1; fcw_ch = c; fcw_data = d;
        @(negedge clk);
        fcw_wr = 1'b0;
        m_sh[c] = d;
    endtask

    // One full sweep from tick (cycle 0) through the edge that ends it (cycle 6).
    task automatic sweep(input logic [3:0] en, input int wr_at, input logic [1:0] wch,
                         input logic [31:0] wdat, input int ov_at, input int clr_at,
                         output logic [3:0][7:0] got);
        logic [7:0] ea [4];
        for (int k = 0; k < 4; k++) m_act[k] = m_sh[k];
        for (int k = 0; k < 4; k++) begin
            ea[k] = m_ph[k][31:24];
            if (en[k]) begin
                m_ph[k]  = m_ph[k] + m_act[k];
                m_smp[k] = 16'h1000 + {8'h00, ea[k]};
            end else begin
                m_ph[k]  = '0;
                m_smp[k] = '0;
            end
        end
        got   = '0;
        ch_en = en;
        for (int c = 0; c < 7; c++) begin
            sample_tick = (c == 0) || (c == ov_at);
            fcw_wr      = (c == wr_at);
            fcw_ch      = wch;
            fcw_data    = wdat;
            overrun_clr = (c == clr_at);
            if (c == wr_at) m_sh[wch] = wdat;
            if (c > 0 && c == ov_at) m_ov = 1'b1;
            else if (c == clr_at)    m_ov = 1'b0;
            @(negedge clk);
            chk("busy", busy, c < 6);
            chk("sample_valid", sample_valid, c == 6);
            if (c >= 1 && c <= 4) begin
                got[c-1] = rom_addr;
                chk("rom_addr", rom_addr, ea[c-1]);
            end
        end
        sample_tick = 1'b0; fcw_wr = 1'b0; overrun_clr = 1'b0;
        for (int k = 0; k < 4; k++) chk("sample", sample_o[k*16 +: 16], m_smp[k]);
        chk("overrun", overrun, m_ov);
    endtask

    initial begin
        logic [3:0][7:0] got;
        int wa, oa, ca;

        vec[0] = '{4'hF, -1, 2'd0, 32'h0,         -1, -1, 32'h00000000, 1'b0};
        vec[1] = '{4'hF, -1, 2'd0, 32'h0,         -1, -1, 32'h00018001, 1'b0};
        vec[2] = '{4'hB, -1, 2'd0, 32'h0,          3, -1, 32'h00020002, 1'b1};
        vec[3] = '{4'hB,  2, 2'd0, 32'h0200_0000, -1,  1, 32'h00008003, 1'b0};
        vec[4] = '{4'hF,  0, 2'd3, 32'h1000_0000, -1, -1, 32'h00000004, 1'b0};
        vec[5] = '{4'hF, -1, 2'd0, 32'h0,          6,  6, 32'h00018006, 1'b1};
        vec[6] = '{4'hF, -1, 2'd0, 32'h0,         -1, -1, 32'h10020008, 1'b1};

        rst_n = 1'b0; sample_tick = 1'b0; fcw_wr = 1'b0; overrun_clr = 1'b0;
        fcw_ch = '0; fcw_data = '0; ch_en = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_sample_o", sample_o, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        wr_fcw(2'd0, 32'h0100_0000);
        wr_fcw(2'd1, 32'h8000_0000);
        wr_fcw(2'd2, 32'h0100_0000);

        for (int i = 0; i < 7; i++) begin
            sweep(vec[i].en, vec[i].wr_at, vec[i].wr_ch, vec[i].wr_data,
                  vec[i].ov_at, vec[i].clr_at, got);
            for (int k = 0; k < 4; k++) chk($sformatf("dir%0d_addr%0d", i, k), got[k], vec[i].ea[k]);
            chk($sformatf("dir%0d_overrun", i), overrun, vec[i].eov);
        end

        // Reset dropped just after E3 of a sweep.
        repeat (2) @(negedge clk);
        ch_en = 4'hF; sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_sample_o", sample_o, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_rst_sample_valid", sample_valid, 0);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        wr_fcw(2'd0, 32'h0100_0000);
        sweep(4'hF, -1, 2'd0, 32'h0, -1, -1, got);
        chk("post_rst_addr0", got[0], 8'h00);
        sweep(4'hF, -1, 2'd0, 32'h0, -1, -1, got);
        chk("post_rst_addr0_step", got[0], 8'h01);
        chk("post_rst_sample0", sample_o[15:0], 16'h1001);

        for (int i = 0; i < 30; i++) begin
            wa = int'($urandom_range(0, 9)); if (wa > 6) wa = -1;
            oa = int'($urandom_range(1, 12)); if (oa > 6) oa = -1;
            ca = int'($urandom_range(0, 12)); if (ca > 6) ca = -1;
            sweep(4'($urandom), wa, 2'($urandom), $urandom, oa, ca, got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
